// File: rtl/tri_bus_owner_arb.sv
// rtl/tri_bus_owner_arb.sv - round-robin owner arbiter for a shared tri-state net
// Grants one agent at a time, bounds each tenure, and forces released cycles between owners.
module tri_bus_owner_arb #(
    parameter int NREQ     = 4,
    parameter int HOLD_MAX = 15,
    parameter int TURN_CYC = 1,
    parameter int CW       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         last,
    output logic [NREQ-1:0]         drv_en,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    owner_vld,
    output logic                    bus_rel,
    output logic                    timeout
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [2:0]      turn_cnt_q, turn_cnt_d;
    logic [NREQ-1:0] drv_en_q, drv_en_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic            bus_rel_q, bus_rel_d;
    logic            timeout_q, timeout_d;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic [IW:0]     cand;
    logic            release_now;

    // Rotating scan starting at rr_ptr; the extra bit lets the sum wrap without overflow.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        drv_en_d    = drv_en_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        bus_rel_d   = bus_rel_q;
        timeout_d   = 1'b0;
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_OWN;
                    drv_en_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    bus_rel_d   = 1'b0;
                    beat_cnt_d  = {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_OWN: begin
                // Priority: dropped request, final beat, tenure limit, keep counting.
                if (!req[owner_q]) begin
                    release_now = 1'b1;
                end else if (last[owner_q]) begin
                    release_now = 1'b1;
                end else if ((HOLD_MAX != 0) && (beat_cnt_q == CW'(HOLD_MAX))) begin
                    release_now = 1'b1;
                    timeout_d   = 1'b1;
                end else if (beat_cnt_q != {CW{1'b1}}) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end

                if (release_now) begin
                    state_d     = ST_TURN;
                    drv_en_d    = '0;
                    owner_vld_d = 1'b0;
                    bus_rel_d   = 1'b1;
                    turn_cnt_d  = 3'(TURN_CYC);
                    rr_ptr_d    = (owner_q == IW'(NREQ-1)) ? '0 : owner_q + 1'b1;
                end
            end
            ST_TURN: begin
                turn_cnt_d = turn_cnt_q - 1'b1;
                if (turn_cnt_q <= 3'd1) begin
                    turn_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                drv_en_d    = '0;
                owner_vld_d = 1'b0;
                bus_rel_d   = 1'b1;
            end
        endcase
    end

    // Async reset so drive enables collapse immediately, not at the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            turn_cnt_q  <= '0;
            drv_en_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            bus_rel_q   <= 1'b1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            drv_en_q    <= drv_en_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            bus_rel_q   <= bus_rel_d;
            timeout_q   <= timeout_d;
        end
    end

    assign drv_en    = drv_en_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign bus_rel   = bus_rel_q;
    assign timeout   = timeout_q;

endmodule
